// File: rtl/dp_ram_arb_pkg.sv
// Shared constants and types for the dual-port RAM port arbiter.
// Optional statistics counters are enabled with DP_RAM_ARB_STATS_EN.
package dp_ram_arb_pkg;

    localparam int DEFAULT_NUM_REQ = 3;
    localparam int STAT_W          = 32;

    // Index width that stays legal when there is only one requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(DEFAULT_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/dp_ram_port_arbiter_rr_pick.sv
// Round-robin pick: rotate the request vector to start at ptr_i and take
// the first set bit, reported as one-hot grant plus binary index.
module dp_ram_rr_pick
    import dp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every output gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ OBI-style masters.
// Define DP_RAM_ARB_STATS_EN to build per-requester grant/stall counters.
module dp_ram_port_arbiter
    import dp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    localparam int IDX_W     = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*NUM_COL-1:0]    req_be_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          ram_en_o,
    output logic                          ram_we_o,
    output logic [NUM_COL-1:0]            ram_be_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic [DATA_WIDTH-1:0]         ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_i,
    input  logic [IDX_W-1:0]              stat_sel_i,
    output logic [STAT_W-1:0]             stat_grant_o,
    output logic [STAT_W-1:0]             stat_stall_o
);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               resp_valid_q, resp_valid_d;
    logic [IDX_W-1:0]   resp_owner_q, resp_owner_d;
    logic [NUM_REQ-1:0] req_eff;
    logic [IDX_W-1:0]   win;
    logic               any_gnt;

    // Masking requests during reset keeps gnt_o and ram_en_o low.
    assign req_eff = rst_i ? '0 : req_i;

    dp_ram_rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req_i(req_eff),
        .ptr_i(rr_ptr_q),
        .gnt_o(gnt_o),
        .idx_o(win),
        .any_o(any_gnt)
    );

    always_comb begin
        ram_en_o    = any_gnt;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) begin
                ram_we_o    = req_we_i[k];
                ram_be_o    = req_we_i[k] ? req_be_i[k*NUM_COL +: NUM_COL] : '0;
                ram_addr_o  = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wdata_o = req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = any_gnt;
        resp_owner_d = resp_owner_q;
        if (any_gnt) begin
            rr_ptr_d     = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
            resp_owner_d = win;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rvalid_o[k] = resp_valid_q && (resp_owner_q == IDX_W'(k));
        end
    end

    // RAM read data is already registered inside the RAM.
    assign rdata_o = ram_rdata_i;

`ifdef DP_RAM_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [NUM_REQ];
    logic [STAT_W-1:0] grant_cnt_d [NUM_REQ];
    logic [STAT_W-1:0] stall_cnt_q [NUM_REQ];
    logic [STAT_W-1:0] stall_cnt_d [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_cnt_d[k] = grant_cnt_q[k];
            stall_cnt_d[k] = stall_cnt_q[k];
            if (gnt_o[k] && grant_cnt_q[k] != '1) begin
                grant_cnt_d[k] = grant_cnt_q[k] + STAT_W'(1);
            end
            if (req_i[k] && !gnt_o[k] && stall_cnt_q[k] != '1) begin
                stall_cnt_d[k] = stall_cnt_q[k] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: these arrays are a handful of flops, not a RAM macro, so
        // clearing them in reset is cheap and intended.
        if (rst_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= '0;
                stall_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= grant_cnt_d[k];
                stall_cnt_q[k] <= stall_cnt_d[k];
            end
        end
    end

    always_comb begin
        stat_grant_o = '0;
        stat_stall_o = '0;
        if (int'(stat_sel_i) < NUM_REQ) begin
            stat_grant_o = grant_cnt_q[stat_sel_i];
            stat_stall_o = stall_cnt_q[stat_sel_i];
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel_i;
    assign stat_grant_o    = '0;
    assign stat_stall_o    = '0;
`endif

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Directed bench for dp_ram_port_arbiter with a write-first byte-enable RAM
// model; stat expectations follow DP_RAM_ARB_STATS_EN.
module tb_dp_ram_port_arbiter;

    logic        clk;
    logic        rst_i;
    logic [2:0]  req_i;
    logic [2:0]  req_we_i;
    logic [11:0] req_be_i;
    logic [23:0] req_addr_i;
    logic [95:0] req_wdata_i;
    logic [2:0]  gnt_o;
    logic [2:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [7:0]  ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic [1:0]  stat_sel_i;
    logic [31:0] stat_grant_o;
    logic [31:0] stat_stall_o;

    int checks   = 0;
    int failures = 0;

    dp_ram_port_arbiter dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .req_we_i    (req_we_i),
        .req_be_i    (req_be_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .stat_sel_i  (stat_sel_i),
        .stat_grant_o(stat_grant_o),
        .stat_stall_o(stat_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first RAM with registered read port.
    logic [31:0] mem [256];
    logic [31:0] ram_merged;

    always_comb begin
        ram_merged = mem[ram_addr_o];
        for (int c = 0; c < 4; c++) begin
            if (ram_we_o && ram_be_o[c]) ram_merged[c*8 +: 8] = ram_wdata_o[c*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (rst_i) begin
            mem[8'h10]  <= 32'hDEADBEEF;
            mem[8'h20]  <= 32'hAAAAAAAA;
            ram_rdata_i <= 32'h0;
        end else if (ram_en_o) begin
            mem[ram_addr_o] <= ram_merged;
            ram_rdata_i     <= ram_merged;
        end
    end

    // Requester contract: a pending, ungranted request must stay asserted.
    logic [2:0] pend;
    initial pend = 3'b000;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            assert (!(pend[k] && !req_i[k])) else begin
                failures++;
                $error("FAIL req_drop_%0d observed=0 expected=1", k);
            end
        end
        pend = rst_i ? 3'b000 : (req_i & ~gnt_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] order [6];

    initial begin
        order[0] = 32'h1; order[1] = 32'h2; order[2] = 32'h4;
        order[3] = 32'h1; order[4] = 32'h2; order[5] = 32'h4;

        rst_i       = 1'b1;
        req_i       = 3'b111;
        req_we_i    = 3'b000;
        req_be_i    = 12'h0;
        req_addr_i  = 24'h0;
        req_wdata_i = 96'h0;
        stat_sel_i  = 2'd2;

        // Reset held three cycles with everyone requesting.
        repeat (3) begin
            cyc();
            check("rst_gnt",    32'(gnt_o),    32'h0);
            check("rst_en",     32'(ram_en_o), 32'h0);
            check("rst_rvalid", 32'(rvalid_o), 32'h0);
        end

        // Contention: order 0,1,2,0,1,2 starting right after reset.
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("cont_gnt",    32'(gnt_o),    order[i]);
            check("cont_en",     32'(ram_en_o), 32'h1);
            check("cont_rvalid", 32'(rvalid_o), (i == 0) ? 32'h0 : order[i-1]);
            cyc();
        end
        req_i = 3'b011;
        #1;
        check("taper_rvalid2", 32'(rvalid_o), 32'h4);
        check("taper_gnt0",    32'(gnt_o),    32'h1);
        cyc();
        req_i = 3'b010;
        #1;
        check("taper_gnt1",    32'(gnt_o),    32'h2);
        check("taper_rvalid0", 32'(rvalid_o), 32'h1);
        cyc();
        req_i = 3'b000;
        #1;
        check("idle_rvalid1", 32'(rvalid_o), 32'h2);
        check("idle_gnt",     32'(gnt_o),    32'h0);
        check("idle_en",      32'(ram_en_o), 32'h0);
        check("idle_we",      32'(ram_we_o), 32'h0);
        check("idle_be",      32'(ram_be_o), 32'h0);

        // Statistics of requester 2 after the contention run.
`ifdef DP_RAM_ARB_STATS_EN
        check("stat_grant2", stat_grant_o, 32'd2);
        check("stat_stall2", stat_stall_o, 32'd4);
`else
        check("stat_grant2", stat_grant_o, 32'd0);
        check("stat_stall2", stat_stall_o, 32'd0);
`endif
        stat_sel_i = 2'd3;
        #1;
        check("stat_grant_oob", stat_grant_o, 32'd0);
        check("stat_stall_oob", stat_stall_o, 32'd0);

        // Single read by requester 1 from 0x10.
        req_i             = 3'b010;
        req_addr_i[15:8]  = 8'h10;
        #1;
        check("rd_gnt",  32'(gnt_o),      32'h2);
        check("rd_en",   32'(ram_en_o),   32'h1);
        check("rd_we",   32'(ram_we_o),   32'h0);
        check("rd_addr", 32'(ram_addr_o), 32'h10);
        cyc();
        req_i = 3'b000;
        #1;
        check("rd_rvalid", 32'(rvalid_o), 32'h2);
        check("rd_rdata",  rdata_o,       32'hDEADBEEF);

        // Byte write by requester 2, then read back by requester 0.
        req_i              = 3'b100;
        req_we_i           = 3'b100;
        req_be_i[11:8]     = 4'b0101;
        req_addr_i[23:16]  = 8'h20;
        req_wdata_i[95:64] = 32'h11223344;
        #1;
        check("wr_gnt",   32'(gnt_o),       32'h4);
        check("wr_we",    32'(ram_we_o),    32'h1);
        check("wr_be",    32'(ram_be_o),    32'h5);
        check("wr_addr",  32'(ram_addr_o),  32'h20);
        check("wr_wdata", ram_wdata_o,      32'h11223344);
        cyc();
        req_i            = 3'b001;
        req_we_i         = 3'b000;
        req_be_i[3:0]    = 4'b1111;
        req_addr_i[7:0]  = 8'h20;
        #1;
        check("wr_rvalid",  32'(rvalid_o), 32'h4);
        check("wr_rdata",   rdata_o,       32'hAA22AA44);
        check("rb_gnt",     32'(gnt_o),    32'h1);
        check("rb_be_mask", 32'(ram_be_o), 32'h0);
        cyc();
        req_i = 3'b000;
        #1;
        check("rb_rvalid", 32'(rvalid_o), 32'h1);
        check("rb_rdata",  rdata_o,       32'hAA22AA44);

        // Reset lands on the edge that would register requester 0's grant.
        req_i           = 3'b001;
        req_addr_i[7:0] = 8'h10;
        #1;
        check("mid_gnt", 32'(gnt_o), 32'h1);
        rst_i = 1'b1;
        #1;
        check("mid_gnt_forced", 32'(gnt_o), 32'h0);
        cyc();
        check("mid_rvalid", 32'(rvalid_o), 32'h0);
        rst_i = 1'b0;
        req_i = 3'b011;
        #1;
        check("post_gnt_ptr0", 32'(gnt_o),    32'h1);
        check("post_rvalid",   32'(rvalid_o), 32'h0);
        cyc();
        req_i = 3'b010;
        #1;
        check("post_gnt1",    32'(gnt_o),    32'h2);
        check("post_rvalid0", 32'(rvalid_o), 32'h1);
        cyc();
        req_i = 3'b000;
        #1;
        check("post_rvalid1", 32'(rvalid_o), 32'h2);
        cyc();
        check("post_quiet", 32'(rvalid_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
